// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: state encoding and shared constants for the FIFO word-to-byte transmitter
package fifo_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CSUM, ST_DONE} state_e;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int IDX_W = 2;
endpackage

// File: rtl/fifo_tx_byte_sel.sv
// fifo_tx_byte_sel: picks one byte of a 32-bit word by index, MSB- or LSB-first
module fifo_tx_byte_sel
  import fifo_tx_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [31:0]      word_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       byte_o
);
  logic [IDX_W-1:0] lane;
  logic [31:0] shifted;
  always_comb begin
    lane = MSB_FIRST ? ~idx_i : idx_i;
    shifted = word_i >> {lane, 3'b000};
    byte_o = shifted[7:0];
  end
endmodule

// File: rtl/fifo_word_byte_tx.sv
// fifo_word_byte_tx: pops 32-bit words from a FWFT FIFO and sends framed bytes over valid/ready.
// Define FIFO_TX_CSUM_EN to append an XOR checksum byte to every frame.
module fifo_word_byte_tx
  import fifo_tx_pkg::*;
#(
  parameter int         FRAME_WORDS = 16,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter bit         MSB_FIRST   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  state_e state_q;
  logic [31:0] buf_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [8:0] wcnt_q;
  logic [7:0] out_data_q, byte_d;
  logic out_valid_q, busy_q;
  logic [15:0] frame_cnt_q;
`ifdef FIFO_TX_CSUM_EN
  logic [7:0] csum_q;
`endif
  logic acc, word_end, more, load_req, frame_end;
  // In DATA the buffer holds a word exactly while out_valid is high, so out_valid doubles as buffer-full
  always_comb begin
    acc = out_valid_q & out_ready;
    word_end = (state_q == ST_DATA) & acc & (idx_q == '1);
    more = wcnt_q != 9'(FRAME_WORDS);
    load_req = rst_n & more & (((state_q == ST_HDR) & acc) | ((state_q == ST_DATA) & (!out_valid_q | word_end)));
    fifo_rd_en = fifo_rd_vld & load_req;
    frame_end = word_end & !more;
    word_d = fifo_rd_en ? fifo_rd_data : buf_q;
    idx_d = fifo_rd_en ? '0 : idx_q + 1'b1;
  end
  fifo_tx_byte_sel #(.MSB_FIRST(MSB_FIRST)) u_sel (
    .word_i(word_d),
    .idx_i (idx_d),
    .byte_o(byte_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q <= '0;
      idx_q <= '0;
      wcnt_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FIFO_TX_CSUM_EN
      csum_q <= '0;
`endif
    end else begin
      if (fifo_rd_en) begin
        buf_q <= fifo_rd_data;
        wcnt_q <= wcnt_q + 9'd1;
      end
      case (state_q)
        ST_IDLE: if (fifo_rd_vld) begin
          state_q <= ST_HDR;
          out_valid_q <= 1'b1;
          out_data_q <= HDR_BYTE;
          busy_q <= 1'b1;
          wcnt_q <= '0;
`ifdef FIFO_TX_CSUM_EN
          csum_q <= '0;
`endif
        end
        ST_HDR: if (acc) begin
          state_q <= ST_DATA;
          out_valid_q <= fifo_rd_en;
          out_data_q <= byte_d;
          idx_q <= idx_d;
        end
        ST_DATA: begin
`ifdef FIFO_TX_CSUM_EN
          if (acc) csum_q <= csum_q ^ out_data_q;
`endif
          if (frame_end) begin
`ifdef FIFO_TX_CSUM_EN
            state_q <= ST_CSUM;
            out_data_q <= csum_q ^ out_data_q;
`else
            state_q <= ST_DONE;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
`endif
          end else if (acc | fifo_rd_en) begin
            out_valid_q <= fifo_rd_en | !word_end;
            out_data_q <= byte_d;
            idx_q <= idx_d;
          end
        end
`ifdef FIFO_TX_CSUM_EN
        ST_CSUM: if (acc) begin
          state_q <= ST_DONE;
          out_valid_q <= 1'b0;
          busy_q <= 1'b0;
        end
`endif
        ST_DONE: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign frame_cnt = frame_cnt_q;
endmodule
